// File: rtl/adder37_share_arb_pkg.sv
// Shared defaults and FSM encoding for the two-requester shared adder.
package adder37_share_arb_pkg;

    localparam int A_W_DEF = 37;
    localparam int B_W_DEF = 35;
    localparam int S_W_DEF = A_W_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder37_share_arb_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // last holds the ID of the previous winner; give the tie to the other one
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/adder37_share_arb.sv
// Shares one A+B adder between two requesters; one transaction in flight,
// round-robin grant, IDLE -> ADD -> RESP, per-requester completion counters.
module adder37_share_arb
    import adder37_share_arb_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int S_W = S_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    input  logic [A_W-1:0] req0_a,
    input  logic [B_W-1:0] req0_b,
    output logic           req0_ready,
    input  logic           req1_valid,
    input  logic [A_W-1:0] req1_a,
    input  logic [B_W-1:0] req1_b,
    output logic           req1_ready,
    output logic           resp0_valid,
    output logic [S_W-1:0] resp0_sum,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    output logic [S_W-1:0] resp1_sum,
    input  logic           resp1_ready,
    output logic [7:0]     done_cnt0,
    output logic [7:0]     done_cnt1
);

    state_t         state_q;
    logic [A_W-1:0] a_q, a_d;
    logic [B_W-1:0] b_q, b_d;
    logic [S_W-1:0] sum_q, sum_d;
    logic           gid_q;
    logic           last_q;
    logic [7:0]     cnt0_q, cnt1_q;
    logic [1:0]     grant;
    logic           in_idle, in_resp;

    rr_arb2 u_arb (
        .req   ({req1_valid, req0_valid}),
        .last  (last_q),
        .grant (grant)
    );

    assign in_idle = (state_q == IDLE);
    assign in_resp = (state_q == RESP);

    // grant already implies the matching valid, so ready needs only the state
    assign req0_ready = in_idle & grant[0];
    assign req1_ready = in_idle & grant[1];

    assign a_d = grant[1] ? req1_a : req0_a;
    assign b_d = grant[1] ? req1_b : req0_b;

    // Single shared adder, driven only from the captured operands
    assign sum_d = {{(S_W-A_W){1'b0}}, a_q} + {{(S_W-B_W){1'b0}}, b_q};

    assign resp0_valid = in_resp & ~gid_q;
    assign resp1_valid = in_resp &  gid_q;
    assign resp0_sum   = sum_q;
    assign resp1_sum   = sum_q;
    assign done_cnt0   = cnt0_q;
    assign done_cnt1   = cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= 8'd0;
            cnt1_q  <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        gid_q   <= grant[1];
                        last_q  <= grant[1];
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    state_q <= RESP;
                end
                RESP: begin
                    if (resp0_valid && resp0_ready) begin
                        cnt0_q  <= cnt0_q + 8'd1;
                        state_q <= IDLE;
                    end else if (resp1_valid && resp1_ready) begin
                        cnt1_q  <= cnt1_q + 8'd1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder37_share_arb.sv
// Directed, table-driven bench for adder37_share_arb.
module tb_adder37_share_arb;

    localparam int A_W = 37;
    localparam int B_W = 35;
    localparam int S_W = 38;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req1_valid;
    logic [A_W-1:0] req0_a, req1_a;
    logic [B_W-1:0] req0_b, req1_b;
    logic           req0_ready, req1_ready;
    logic           resp0_valid, resp1_valid;
    logic [S_W-1:0] resp0_sum, resp1_sum;
    logic           resp0_ready, resp1_ready;
    logic [7:0]     done_cnt0, done_cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder37_share_arb #(.A_W(A_W), .B_W(B_W), .S_W(S_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_sum   (resp0_sum),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_sum   (resp1_sum),
        .resp1_ready (resp1_ready),
        .done_cnt0   (done_cnt0),
        .done_cnt1   (done_cnt1)
    );

    typedef struct {
        bit             id;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic [S_W-1:0] sum;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated transaction from requester id with resp_ready held high.
    task automatic txn(input bit id, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                       input logic [S_W-1:0] exp, input string name);
        int k;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 8) begin tick(); k++; end
        check({name, " ready"}, {63'd0, id ? req1_ready : req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
        if (id) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        #1;
        check({name, " no resp in ADD"}, {62'd0, resp1_valid, resp0_valid}, 64'd0);
        tick();
        check({name, " resp valid"}, {62'd0, resp1_valid, resp0_valid}, id ? 64'd2 : 64'd1);
        check({name, " sum"}, 64'(id ? resp1_sum : resp0_sum), 64'(exp));
        tick();
        check({name, " resp dropped"}, {62'd0, resp1_valid, resp0_valid}, 64'd0);
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    initial begin
        int k;
        bit winner;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
        resp0_ready = 0; resp1_ready = 0;

        vecs[0] = '{1'b0, 37'h00_0000_0000, 35'h0_0000_0000, 38'h00_0000_0000};
        vecs[1] = '{1'b1, 37'h1F_FFFF_FFFF, 35'h7_FFFF_FFFF, 38'h27_FFFF_FFFE};
        vecs[2] = '{1'b0, 37'h12_3456_789A, 35'h1_1111_1111, 38'h13_4567_89AB};
        vecs[3] = '{1'b1, 37'h00_0000_0000, 35'h7_FFFF_FFFF, 38'h07_FFFF_FFFF};
        vecs[4] = '{1'b0, 37'h10_0000_0000, 35'h4_0000_0000, 38'h14_0000_0000};
        vecs[5] = '{1'b1, 37'h1F_FFFF_FFFF, 35'h0_0000_0001, 38'h20_0000_0000};

        // Reset state
        #12;
        check("reset readies", {62'd0, req1_ready, req0_ready}, 64'd0);
        check("reset valids", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        check("reset sums", {26'd0, resp0_sum} | {26'd0, resp1_sum}, 64'd0);
        check("reset counters", {48'd0, done_cnt1, done_cnt0}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle readies", {62'd0, req1_ready, req0_ready}, 64'd0);

        // Carry into bit 37 from a single requester-0 transaction
        txn(1'b0, 37'h1F_FFFF_FFFF, 35'h1, 38'h20_0000_0000, "carry");
        check("carry cnt0", {56'd0, done_cnt0}, 64'd1);
        check("carry cnt1", {56'd0, done_cnt1}, 64'd0);

        // Both valid from reset: grants alternate starting with requester 0
        do_reset();
        req0_valid = 1; req0_a = 37'd5;   req0_b = 35'd3;
        req1_valid = 1; req1_a = 37'd100; req1_b = 35'd7;
        resp0_ready = 1; resp1_ready = 1;
        for (int t = 0; t < 4; t++) begin
            #1;
            k = 0;
            while (!(req0_ready || req1_ready) && k < 8) begin tick(); k++; end
            check("tie not both ready", {63'd0, req0_ready & req1_ready}, 64'd0);
            winner = req1_ready;
            check("tie grant order", {63'd0, winner}, 64'(t % 2));
            tick();
            tick();
            if (winner) check("tie sum1", 64'(resp1_sum), 64'd107);
            else        check("tie sum0", 64'(resp0_sum), 64'd8);
            tick();
        end
        req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
        #1;
        check("tie counters", {48'd0, done_cnt1, done_cnt0}, {48'd0, 8'd2, 8'd2});

        // Table of operand patterns, alternating requesters
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));
        end
        check("table counters", {48'd0, done_cnt1, done_cnt0}, {48'd0, 8'd5, 8'd5});

        // Stalled response on requester 1; requester 0 waits, stray resp0_ready ignored
        req1_valid = 1; req1_a = 37'hFF; req1_b = 35'h1;
        #1;
        k = 0;
        while (!req1_ready && k < 8) begin tick(); k++; end
        check("stall ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 0; req1_a = '0; req0_valid = 1; req0_a = 37'h3; req0_b = 35'h4;
        tick();
        for (int c = 0; c < 10; c++) begin
            resp0_ready = c[0];
            #1;
            check("stall resp1_valid", {63'd0, resp1_valid}, 64'd1);
            check("stall resp1_sum", 64'(resp1_sum), 64'h100);
            check("stall no req0_ready", {62'd0, req0_ready, resp0_valid}, 64'd0);
            tick();
        end
        resp0_ready = 0; resp1_ready = 1;
        tick();
        check("stall done", {63'd0, resp1_valid}, 64'd0);
        check("stall cnt1", {56'd0, done_cnt1}, 64'd6);
        check("stall sum held", 64'(resp1_sum), 64'h100);
        check("stall req0 now ready", {63'd0, req0_ready}, 64'd1);
        req0_valid = 0; resp1_ready = 0;

        // Reset during RESP discards the transaction
        req1_valid = 1; req1_a = 37'h7; req1_b = 35'h9;
        #1;
        k = 0;
        while (!req1_ready && k < 8) begin tick(); k++; end
        tick();
        req1_valid = 0;
        tick();
        check("pre-reset resp1_valid", {63'd0, resp1_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        check("async reset sum", 64'(resp1_sum), 64'd0);
        check("async reset counters", {48'd0, done_cnt1, done_cnt0}, 64'd0);
        resp1_ready = 1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post-reset no resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        end
        check("post-reset counters", {48'd0, done_cnt1, done_cnt0}, 64'd0);
        resp1_ready = 0;
        req0_valid = 1; req1_valid = 1;
        #1;
        check("post-reset tie", {62'd0, req1_ready, req0_ready}, 64'd1);
        req0_valid = 0; req1_valid = 0;

        // 256 back-to-back requester-0 transactions wrap done_cnt0
        do_reset();
        req0_valid = 1; req0_a = 37'd1; req0_b = 35'd2; resp0_ready = 1;
        for (int c = 0; c < 3 * 255; c++) tick();
        check("wrap cnt0 255", {56'd0, done_cnt0}, 64'd255);
        for (int c = 0; c < 3; c++) tick();
        check("wrap cnt0 0", {56'd0, done_cnt0}, 64'd0);
        check("wrap sum", 64'(resp0_sum), 64'd3);
        req0_valid = 0; resp0_ready = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adder37_share_arb.md
ADDER37_SHARE_ARB -- requirements
Module: adder37_share_arb

Interface
REQ-001 Parameter A_W, default 37, first-operand width.
REQ-002 Parameter B_W, default 35, second-operand width, zero-extended to A_W before the add.
REQ-003 Parameter S_W, default 38 (A_W+1), sum width including carry-out.
REQ-004 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port req0_valid  in  1  requester 0 holds operands valid.
REQ-007 Port req0_a  in  A_W  requester 0 first operand.
REQ-008 Port req0_b  in  B_W  requester 0 second operand.
REQ-009 Port req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-010 Ports req1_valid, req1_a, req1_b, req1_ready: same directions, widths and meanings for requester 1.
REQ-011 Port resp0_valid  out  1  result for requester 0 available.
REQ-012 Port resp0_sum  out  S_W  result for requester 0.
REQ-013 Port resp0_ready  in  1  requester 0 consumes the result.
REQ-014 Ports resp1_valid, resp1_sum, resp1_ready: same as requester 0, for requester 1.
REQ-015 Port done_cnt0  out  8  completed requester-0 transactions, wrapping.
REQ-016 Port done_cnt1  out  8  completed requester-1 transactions, wrapping.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, ADD, RESP.
REQ-018 Only one transaction SHALL be in flight at a time.
REQ-019 In IDLE the grant SHALL be round-robin. A single valid requester wins. If both requesters are valid, the winner is the one not granted last.
REQ-020 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only while that requester is valid. It is a combinational function of valid and state. Both readies are never high together.
REQ-021 On acceptance (valid and ready), the block SHALL register the operands and the grant ID, update the last-grant pointer, and move to ADD.
REQ-022 In ADD the block SHALL compute sum = A + zero-extended B, capture the carry-out in bit S_W-1, register the sum, and move to RESP.
REQ-023 In RESP, respN_valid SHALL be high for the granted ID only. respN_sum is stable while valid is high.
REQ-024 respN_valid SHALL stay high until respN_ready is sampled high. Then the block moves to IDLE and increments done_cntN, wrapping from 255 to 0.
REQ-025 Latency: resp_valid SHALL rise two edges after the accepting edge.
REQ-026 Minimum transaction period SHALL be 3 cycles: IDLE, ADD, and RESP with ready held high.
REQ-027 When a resp_ready arrives that is not for the granted ID, or arrives while resp_valid is low, it SHALL be ignored.
REQ-028 While busy (ADD or RESP), changes on req inputs SHALL have no effect.
REQ-029 When both requesters are valid continuously, grants SHALL strictly alternate 0,1,0,1...
REQ-030 respN_sum SHALL hold its last value outside RESP. It is not cleared on completion.

Reset
REQ-031 While rst_n is low, the block SHALL asynchronously clear all state: state=IDLE, operand and sum registers=0, grant ID=0, last-grant pointer=1 (requester 0 wins the first tie), done counters=0.
REQ-032 After reset: all ready and valid outputs are 0 until a request arrives, and resp sums are 0.
REQ-033 Reset asserted during ADD or RESP SHALL discard the transaction. No response is produced after release, and no counter increments.

Structure
REQ-034 A shared package SHALL hold the A_W, B_W and S_W defaults and the FSM state encoding (IDLE=2'd0, ADD=2'd1, RESP=2'd2).
REQ-035 The two-way round-robin grant logic SHALL be a sub-module named rr_arb2. It has inputs req[1:0] and last, and outputs a one-hot grant.
REQ-036 The adder SHALL be a single shared instance fed only from the operand registers.

Verification
REQ-037 Scenario: reset, then req0 alone with a=37'h1F_FFFF_FFFF, b=1, resp0_ready high -> resp0_sum=38'h20_0000_0000 two edges after accept, and done_cnt0=1.
REQ-038 Scenario: both valid from reset, readies high, 4 transactions -> grant order 0,1,0,1; each sum is correct; done_cnt0=done_cnt1=2.
REQ-039 Scenario: a=2^37-1, b=2^35-1 -> sum=2^37+2^35-2, with carry bit set.
REQ-040 Scenario: resp1_ready held low for 10 cycles -> resp1_valid and resp1_sum stay stable, req0 receives no ready, and completion occurs on the first ready-high edge.
REQ-041 Scenario: rst_n pulsed low during RESP -> no resp_valid after release, counters=0, and the next tie grants requester 0.
REQ-042 Scenario: 256 requester-0 transactions -> done_cnt0 wraps to 0.
